// File: rtl/regfile_wb_queue_if.sv
// Bus between a multi-cycle producer, the write-back queue and the register file write port.
// Also carries the two decode forwarding lookups and the queue status.
interface regfile_wb_queue_if #(
    parameter int PTRW = 2
);
    logic            enq_valid;
    logic            enq_ready;
    logic [2:0]      enq_reg;
    logic [15:0]     enq_data;
    logic            port_free;
    logic            write;
    logic [2:0]      writeregsel;
    logic [15:0]     writedata;
    logic [2:0]      read1regsel;
    logic [2:0]      read2regsel;
    logic            fwd1_hit;
    logic [15:0]     fwd1_data;
    logic            fwd2_hit;
    logic [15:0]     fwd2_data;
    logic            full;
    logic            empty;
    logic [PTRW:0]   count;

    modport master (
        output enq_valid, enq_reg, enq_data, port_free, read1regsel, read2regsel,
        input  enq_ready, write, writeregsel, writedata,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, full, empty, count
    );

    modport slave (
        input  enq_valid, enq_reg, enq_data, port_free, read1regsel, read2regsel,
        output enq_ready, write, writeregsel, writedata,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, full, empty, count
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the register file write port, with
// youngest-first forwarding of queued values to two decode lookups.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_queue_if.slave   wbq
);
    logic [DEPTH-1:0] r_vld;
    logic [2:0]       r_reg  [DEPTH];
    logic [15:0]      r_data [DEPTH];
    logic [PTRW-1:0]  r_head;
    logic [PTRW-1:0]  r_tail;
    logic [PTRW:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_deq;
    logic [16:0]      w_fwd1;
    logic [16:0]      w_fwd2;

    assign w_full  = (r_count == (PTRW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_enq   = wbq.enq_valid & ~w_full;
    assign w_deq   = ~w_empty & wbq.port_free;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // enq and deq never target the same slot: enq needs !full, deq needs !empty
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset; valid bits and the empty gate hide stale contents.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_reg[r_tail]  <= wbq.enq_reg;
            r_data[r_tail] <= wbq.enq_data;
        end
    end

    // Walk oldest to youngest from head; a later match overrides, so the youngest wins.
    function automatic logic [16:0] lookup(input logic [2:0] sel);
        logic [16:0]     res;
        logic [PTRW-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PTRW'(i);
            if (r_vld[idx] && (r_reg[idx] == sel))
                res = {1'b1, r_data[idx]};
        end
        return res;
    endfunction

    always_comb begin
        w_fwd1 = lookup(wbq.read1regsel);
        w_fwd2 = lookup(wbq.read2regsel);
    end

    always_comb begin
        wbq.writeregsel = '0;
        wbq.writedata   = '0;
        if (!w_empty) begin
            wbq.writeregsel = r_reg[r_head];
            wbq.writedata   = r_data[r_head];
        end
    end

    assign wbq.enq_ready = ~w_full;
    assign wbq.write     = w_deq;
    assign wbq.fwd1_hit  = w_fwd1[16];
    assign wbq.fwd1_data = w_fwd1[15:0];
    assign wbq.fwd2_hit  = w_fwd2[16];
    assign wbq.fwd2_data = w_fwd2[15:0];
    assign wbq.full      = w_full;
    assign wbq.empty     = w_empty;
    assign wbq.count     = r_count;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: a reference queue predicts every
// drained write, status flag and forwarding result each cycle.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] d;
    } ent_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    ent_t q[$];

    regfile_wb_queue_if #(.PTRW(PTRW)) wbq ();

    regfile_wb_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk (clk),
        .rst (rst),
        .wbq (wbq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] fwd_model(input logic [2:0] sel);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].r == sel) return {1'b1, q[i].d};
        return '0;
    endfunction

    // Reference model: inputs only change just after posedge, so negedge sees settled values.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
        end else begin
            automatic int          n     = q.size();
            automatic logic        exp_w = (n > 0) && wbq.port_free;
            automatic logic        acc   = wbq.enq_valid && (n < DEPTH);
            automatic logic [16:0] f1    = fwd_model(wbq.read1regsel);
            automatic logic [16:0] f2    = fwd_model(wbq.read2regsel);
            chk("write",     wbq.write, exp_w);
            chk("wr_sel",    wbq.writeregsel, (n > 0) ? q[0].r : 3'd0);
            chk("wr_data",   wbq.writedata,   (n > 0) ? q[0].d : 16'd0);
            chk("count",     wbq.count, n);
            chk("empty",     wbq.empty, n == 0);
            chk("full",      wbq.full,  n == DEPTH);
            chk("enq_ready", wbq.enq_ready, n < DEPTH);
            chk("fwd1_hit",  wbq.fwd1_hit,  f1[16]);
            chk("fwd1_data", wbq.fwd1_data, f1[15:0]);
            chk("fwd2_hit",  wbq.fwd2_hit,  f2[16]);
            chk("fwd2_data", wbq.fwd2_data, f2[15:0]);
            if (exp_w) void'(q.pop_front());
            if (acc) q.push_back('{r: wbq.enq_reg, d: wbq.enq_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [2:0] r, input logic [15:0] d);
        wbq.enq_valid = 1'b1;
        wbq.enq_reg   = r;
        wbq.enq_data  = d;
        tick();
    endtask

    initial begin
        rst             = 1'b0;
        wbq.enq_valid   = 1'b0;
        wbq.enq_reg     = '0;
        wbq.enq_data    = '0;
        wbq.port_free   = 1'b0;
        wbq.read1regsel = '0;
        wbq.read2regsel = '0;
        repeat (2) tick();

        // reset and idle: lookups miss everywhere
        rst = 1'b1;
        for (int r = 0; r < 8; r++) begin
            wbq.read1regsel = 3'(r);
            tick();
        end
        @(negedge clk);
        chk("idle_empty", wbq.empty, 1'b1);
        chk("idle_count", wbq.count, 3'd0);

        // single write drains on the next edge
        wbq.port_free   = 1'b1;
        wbq.read1regsel = 3'd3;
        enq(3'd3, 16'hBEEF);
        wbq.enq_valid = 1'b0;
        @(negedge clk);
        chk("single_write", wbq.write, 1'b1);
        chk("single_sel",   wbq.writeregsel, 3'd3);
        chk("single_data",  wbq.writedata, 16'hBEEF);
        chk("single_fwd",   wbq.fwd1_hit, 1'b1);
        tick();
        @(negedge clk);
        chk("single_empty", wbq.empty, 1'b1);
        chk("single_nowr",  wbq.write, 1'b0);

        // fill while stalled; fifth request must be refused
        wbq.port_free = 1'b0;
        for (int k = 1; k <= 5; k++) enq(3'(k), 16'(k));
        wbq.enq_valid = 1'b0;
        @(negedge clk);
        chk("fill_full",  wbq.full, 1'b1);
        chk("fill_count", wbq.count, 3'd4);
        chk("fill_ready", wbq.enq_ready, 1'b0);
        wbq.port_free = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("fill_drained", wbq.empty, 1'b1);

        // youngest match forwarding on lookup B
        wbq.port_free   = 1'b0;
        wbq.read2regsel = 3'd6;
        enq(3'd6, 16'h1111);
        enq(3'd6, 16'h2222);
        wbq.enq_valid = 1'b0;
        @(negedge clk);
        chk("young_hit",  wbq.fwd2_hit, 1'b1);
        chk("young_data", wbq.fwd2_data, 16'h2222);
        wbq.port_free = 1'b1;
        tick();
        wbq.port_free = 1'b0;
        @(negedge clk);
        chk("young_d1", wbq.fwd2_data, 16'h2222);
        wbq.port_free = 1'b1;
        tick();
        wbq.port_free = 1'b0;
        @(negedge clk);
        chk("young_miss", wbq.fwd2_hit, 1'b0);
        chk("young_zero", wbq.fwd2_data, 16'h0);

        // steady three entries with enqueue and drain each cycle, wrapping pointers
        for (int k = 0; k < 3; k++) enq(3'(k), 16'hC000 + 16'(k));
        wbq.port_free = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wbq.read1regsel = 3'(k % 3);
            wbq.enq_valid   = 1'b1;
            wbq.enq_reg     = 3'(k % 3);
            wbq.enq_data    = 16'hD000 + 16'(k);
            tick();
            @(negedge clk);
            chk("wrap_count", wbq.count, 3'd3);
        end
        wbq.enq_valid = 1'b0;

        // reset with entries queued and a simultaneous enqueue
        tick();
        wbq.port_free = 1'b0;
        rst           = 1'b0;
        wbq.enq_valid = 1'b1;
        wbq.enq_reg   = 3'd7;
        wbq.enq_data  = 16'hFFFF;
        tick();
        rst           = 1'b1;
        wbq.enq_valid = 1'b0;
        wbq.port_free = 1'b1;
        @(negedge clk);
        chk("rst_count", wbq.count, 3'd0);
        chk("rst_write", wbq.write, 1'b0);
        chk("rst_empty", wbq.empty, 1'b1);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
